// File: rtl/sysbus_timer.sv
// sysbus_timer: memory-mapped 64-bit timer/compare unit on the system bus.
// Provides MTIME with a programmable prescaler, a 64-bit compare with
// optional auto-reload, a sticky PENDING flag and a level timer interrupt.
// Read data is registered and valid one cycle after the read request.
module sysbus_timer #(
    parameter int          PRESCALE_W   = 16,
    parameter int unsigned RST_PRESCALE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        system_bus_en,
    input  logic        system_bus_rdwr,
    input  logic [31:0] system_bus_addr,
    input  logic [31:0] system_bus_wr_data,
    input  logic [3:0]  system_bus_mask,
    output logic [31:0] system_bus_rd_data,
    output logic        timer_irq
);

    localparam logic [2:0] A_MTIME_LO = 3'd0;
    localparam logic [2:0] A_MTIME_HI = 3'd1;
    localparam logic [2:0] A_CMP_LO   = 3'd2;
    localparam logic [2:0] A_CMP_HI   = 3'd3;
    localparam logic [2:0] A_CTRL     = 3'd4;
    localparam logic [2:0] A_STATUS   = 3'd5;
    localparam logic [2:0] A_PRESCALE = 3'd6;

    // Byte-lane merge: lanes with a set mask bit take the new data.
    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  mask);
        logic [31:0] v;
        v = old_val;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) v[8*i +: 8] = new_val[8*i +: 8];
        end
        return v;
    endfunction

    // Architectural state
    logic [63:0]           r_mtime;
    logic [63:0]           r_cmp;
    logic                  r_en;
    logic                  r_autoreload;
    logic                  r_irq_en;
    logic                  r_pending;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic [31:0]           r_shadow;
    logic [31:0]           r_rd_data;
    logic                  r_irq;

    // Decoded request
    logic       w_wr;
    logic       w_rd;
    logic       w_any_lane;
    logic [2:0] w_sel;

    // Next-state values
    logic                  w_match;
    logic                  w_tick;
    logic [63:0]           w_mtime_base;
    logic [63:0]           w_mtime_nxt;
    logic [63:0]           w_cmp_nxt;
    logic                  w_en_nxt;
    logic                  w_autoreload_nxt;
    logic                  w_irq_en_nxt;
    logic                  w_pending_nxt;
    logic                  w_w1c;
    logic [31:0]           w_pre32;
    logic [PRESCALE_W-1:0] w_prescale_nxt;
    logic [PRESCALE_W-1:0] w_pcnt_nxt;
    logic [31:0]           w_rd_nxt;
    logic                  w_unused;

    assign w_sel      = system_bus_addr[4:2];
    assign w_wr       = system_bus_en & system_bus_rdwr;
    assign w_rd       = system_bus_en & ~system_bus_rdwr;
    assign w_any_lane = |system_bus_mask;

    // Address bits outside [4:2] alias and are deliberately ignored.
    assign w_unused = ^{system_bus_addr[31:5], system_bus_addr[1:0]};

    // Compare and prescaler tick, both from registered state only.
    assign w_match = r_en && (r_mtime >= r_cmp);
    assign w_tick  = r_en && (r_pcnt == r_prescale);

    // Next-state logic: bus write > autoreload clear > tick increment.
    always_comb begin
        // Timer-driven MTIME update, then byte-lane bus writes on top
        if (r_autoreload && w_match)
            w_mtime_base = '0;
        else if (w_tick)
            w_mtime_base = r_mtime + 64'd1;
        else
            w_mtime_base = r_mtime;

        w_mtime_nxt = w_mtime_base;
        w_cmp_nxt   = r_cmp;
        if (w_wr && w_sel == A_MTIME_LO)
            w_mtime_nxt[31:0]  = f_merge(w_mtime_base[31:0], system_bus_wr_data, system_bus_mask);
        if (w_wr && w_sel == A_MTIME_HI)
            w_mtime_nxt[63:32] = f_merge(w_mtime_base[63:32], system_bus_wr_data, system_bus_mask);
        if (w_wr && w_sel == A_CMP_LO)
            w_cmp_nxt[31:0]    = f_merge(r_cmp[31:0], system_bus_wr_data, system_bus_mask);
        if (w_wr && w_sel == A_CMP_HI)
            w_cmp_nxt[63:32]   = f_merge(r_cmp[63:32], system_bus_wr_data, system_bus_mask);

        // CTRL lives entirely in byte lane 0
        w_en_nxt         = r_en;
        w_autoreload_nxt = r_autoreload;
        w_irq_en_nxt     = r_irq_en;
        if (w_wr && w_sel == A_CTRL && system_bus_mask[0]) begin
            w_en_nxt         = system_bus_wr_data[0];
            w_autoreload_nxt = system_bus_wr_data[1];
            w_irq_en_nxt     = system_bus_wr_data[2];
        end

        // PENDING: a match in the same cycle beats the W1C
        w_w1c         = w_wr && (w_sel == A_STATUS) && system_bus_mask[0] && system_bus_wr_data[0];
        w_pending_nxt = w_match | (r_pending & ~w_w1c);

        // Prescaler reload register and counter
        w_pre32        = f_merge(32'(r_prescale), system_bus_wr_data, system_bus_mask);
        w_prescale_nxt = r_prescale;
        w_pcnt_nxt     = r_pcnt;
        if (r_en)
            w_pcnt_nxt = w_tick ? '0 : r_pcnt + 1'b1;
        if (w_wr && w_sel == A_PRESCALE && w_any_lane) begin
            w_prescale_nxt = w_pre32[PRESCALE_W-1:0];
            w_pcnt_nxt     = '0;
        end

        // Read mux on the pre-edge register values
        case (w_sel)
            A_MTIME_LO: w_rd_nxt = r_mtime[31:0];
            A_MTIME_HI: w_rd_nxt = r_shadow;
            A_CMP_LO:   w_rd_nxt = r_cmp[31:0];
            A_CMP_HI:   w_rd_nxt = r_cmp[63:32];
            A_CTRL:     w_rd_nxt = {29'd0, r_irq_en, r_autoreload, r_en};
            A_STATUS:   w_rd_nxt = {31'd0, r_pending};
            A_PRESCALE: w_rd_nxt = 32'(r_prescale);
            default:    w_rd_nxt = 32'd0;
        endcase
    end

    // Timer, compare, control and interrupt state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime      <= '0;
            r_cmp        <= '1;
            r_en         <= 1'b0;
            r_autoreload <= 1'b0;
            r_irq_en     <= 1'b0;
            r_pending    <= 1'b0;
            r_prescale   <= PRESCALE_W'(RST_PRESCALE);
            r_pcnt       <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_mtime      <= w_mtime_nxt;
            r_cmp        <= w_cmp_nxt;
            r_en         <= w_en_nxt;
            r_autoreload <= w_autoreload_nxt;
            r_irq_en     <= w_irq_en_nxt;
            r_pending    <= w_pending_nxt;
            r_prescale   <= w_prescale_nxt;
            r_pcnt       <= w_pcnt_nxt;
            r_irq        <= w_pending_nxt & w_irq_en_nxt;
        end
    end

    // Registered read data plus the MTIME_HI shadow captured on MTIME_LO reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
            r_shadow  <= '0;
        end else if (w_rd) begin
            r_rd_data <= w_rd_nxt;
            if (w_sel == A_MTIME_LO)
                r_shadow <= r_mtime[63:32];
        end
    end

    assign system_bus_rd_data = r_rd_data;
    assign timer_irq          = r_irq;

endmodule

// File: tb/tb_sysbus_timer.sv
// Self-checking bench for sysbus_timer: directed vectors and sequences plus
// randomized bus traffic compared every cycle against a behavioural model.
module tb_sysbus_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rdwr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic        irq;

    int n_chk  = 0;
    int n_pass = 0;

    sysbus_timer #(.PRESCALE_W(16), .RST_PRESCALE(0)) dut (
        .clk                (clk),
        .rst                (rst),
        .system_bus_en      (en),
        .system_bus_rdwr    (rdwr),
        .system_bus_addr    (addr),
        .system_bus_wr_data (wdata),
        .system_bus_mask    (mask),
        .system_bus_rd_data (rdata),
        .timer_irq          (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [63:0] m_mtime, m_cmp;
    logic        m_en, m_ar, m_ie, m_pend, m_irq;
    logic [15:0] m_pre, m_cnt;
    logic [31:0] m_shadow, m_rd;

    typedef struct {
        logic [2:0]  off;
        logic [31:0] exp;
    } vec_t;
    vec_t rst_tab[8];

    function automatic logic [31:0] lanes(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock of the model, given the request presented in that cycle.
    task automatic model_step(input logic r, input logic e, input logic w,
                              input logic [2:0] a, input logic [31:0] d, input logic [3:0] mk);
        logic [31:0] bm;
        logic        hit, tick, clr;
        logic [63:0] nt;
        logic [15:0] pre_n, cnt_n;
        logic        en_n, ar_n, ie_n, pend_n;
        if (r) begin
            m_mtime = 0; m_cmp = '1; m_en = 0; m_ar = 0; m_ie = 0; m_pend = 0;
            m_pre = 0; m_cnt = 0; m_shadow = 0; m_rd = 0; m_irq = 0;
            return;
        end
        bm   = lanes(mk);
        hit  = m_en && (m_mtime >= m_cmp);
        tick = m_en && (m_cnt == m_pre);
        if (e && !w) begin
            case (a)
                3'd0: begin m_rd = m_mtime[31:0]; end
                3'd1: m_rd = m_shadow;
                3'd2: m_rd = m_cmp[31:0];
                3'd3: m_rd = m_cmp[63:32];
                3'd4: m_rd = {29'd0, m_ie, m_ar, m_en};
                3'd5: m_rd = {31'd0, m_pend};
                3'd6: m_rd = {16'd0, m_pre};
                default: m_rd = 0;
            endcase
            if (a == 3'd0) m_shadow = m_mtime[63:32];
        end
        nt = (m_ar && hit) ? 64'd0 : (tick ? m_mtime + 1 : m_mtime);
        cnt_n = m_en ? (tick ? 16'd0 : m_cnt + 16'd1) : m_cnt;
        pre_n = m_pre; en_n = m_en; ar_n = m_ar; ie_n = m_ie;
        clr = 0;
        if (e && w) begin
            case (a)
                3'd0: nt[31:0]  = (nt[31:0]  & ~bm) | (d & bm);
                3'd1: nt[63:32] = (nt[63:32] & ~bm) | (d & bm);
                3'd2: m_cmp[31:0]  = (m_cmp[31:0]  & ~bm) | (d & bm);
                3'd3: m_cmp[63:32] = (m_cmp[63:32] & ~bm) | (d & bm);
                3'd4: if (mk[0]) begin en_n = d[0]; ar_n = d[1]; ie_n = d[2]; end
                3'd5: clr = mk[0] & d[0];
                3'd6: if (mk != 0) begin
                    pre_n = (m_pre & ~bm[15:0]) | (d[15:0] & bm[15:0]);
                    cnt_n = 0;
                end
                default: ;
            endcase
        end
        pend_n  = hit | (m_pend & ~clr);
        m_mtime = nt; m_cnt = cnt_n; m_pre = pre_n;
        m_en = en_n; m_ar = ar_n; m_ie = ie_n; m_pend = pend_n;
        m_irq = pend_n & ie_n;
    endtask

    // Present one request for one clock, then compare outputs with the model.
    task automatic cyc(input logic r, input logic e, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] mk, output logic [31:0] got);
        rst = r; en = e; rdwr = w; addr = a; wdata = d; mask = mk;
        model_step(r, e, w, a[4:2], d, mk);
        @(negedge clk);
        got = rdata;
        chk("rd_data", rdata, m_rd);
        chk("timer_irq", irq, m_irq);
        rst = 0; en = 0; rdwr = 0; mask = 0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] mk = 4'hF);
        logic [31:0] g;
        cyc(0, 1, 1, {27'd0, off, 2'b00}, d, mk, g);
    endtask

    task automatic rd(input logic [2:0] off, output logic [31:0] g);
        cyc(0, 1, 0, {27'd0, off, 2'b00}, 32'd0, 4'h0, g);
    endtask

    task automatic idle(input int n);
        logic [31:0] g;
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'd0, 32'd0, 4'h0, g);
    endtask

    task automatic check_reset_table();
        logic [31:0] g;
        for (int i = 0; i < 8; i++) begin
            rd(rst_tab[i].off, g);
            chk($sformatf("reset_read_off%0d", i), g, rst_tab[i].exp);
            chk("reset_irq", irq, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] g, lo, hi;
        logic [31:0] seq_exp[8];

        rst_tab[0] = '{3'd0, 32'h0};
        rst_tab[1] = '{3'd1, 32'h0};
        rst_tab[2] = '{3'd2, 32'hFFFF_FFFF};
        rst_tab[3] = '{3'd3, 32'hFFFF_FFFF};
        rst_tab[4] = '{3'd4, 32'h0};
        rst_tab[5] = '{3'd5, 32'h0};
        rst_tab[6] = '{3'd6, 32'h0};
        rst_tab[7] = '{3'd7, 32'h0};
        seq_exp = '{0, 1, 2, 3, 4, 5, 0, 1};

        rst = 1; en = 0; rdwr = 0; addr = 0; wdata = 0; mask = 0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0, g);
        cyc(1, 0, 0, 0, 0, 0, g);

        // Reset values of every offset
        check_reset_table();

        // Prescaler: PRESCALE=3 gives one tick every 4 clocks
        wr(3'd6, 32'd3);
        wr(3'd4, 32'd1);
        idle(40);
        rd(3'd0, g);
        chk("prescale3_mtime", g, 32'd10);
        wr(3'd6, 32'd0);
        idle(8);
        rd(3'd0, g);
        chk("prescale0_mtime", g, 32'd18);

        // Atomic 64-bit read across the low-word carry
        wr(3'd4, 32'd0);
        wr(3'd6, 32'd0);
        wr(3'd0, 32'hFFFF_FFFE);
        wr(3'd1, 32'd0);
        wr(3'd4, 32'd1);
        idle(1);
        rd(3'd0, lo);
        rd(3'd1, hi);
        chk("carry_lo", lo, 32'hFFFF_FFFF);
        chk("carry_hi", hi, 32'd0);

        // Compare, interrupt and W1C-vs-match priority
        wr(3'd4, 32'd0);
        wr(3'd0, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd2, 32'd20);
        wr(3'd3, 32'd0);
        wr(3'd5, 32'd1);
        wr(3'd4, 32'd5);
        idle(20);
        chk("irq_before_match", irq, 1'b0);
        idle(1);
        chk("irq_after_match", irq, 1'b1);
        wr(3'd5, 32'd1);
        rd(3'd5, g);
        chk("pending_w1c_vs_match", g, 32'd1);
        chk("irq_held", irq, 1'b1);
        wr(3'd3, 32'd1);
        wr(3'd5, 32'd1);
        chk("irq_cleared", irq, 1'b0);
        rd(3'd5, g);
        chk("pending_cleared", g, 32'd0);

        // Autoreload wraps MTIME to 0 on match
        wr(3'd4, 32'd0);
        wr(3'd0, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd3, 32'd0);
        wr(3'd2, 32'd5);
        wr(3'd5, 32'd1);
        wr(3'd4, 32'd7);
        for (int i = 0; i < 8; i++) begin
            rd(3'd0, g);
            chk($sformatf("autoreload_seq%0d", i), g, seq_exp[i]);
        end
        rd(3'd5, g);
        chk("autoreload_pending", g, 32'd1);

        // Byte-masked write while frozen
        wr(3'd4, 32'd0);
        wr(3'd0, 32'h1122_3344);
        wr(3'd0, 32'hAABB_CCDD, 4'b0101);
        rd(3'd0, g);
        chk("masked_write", g, 32'h11BB_33DD);

        // Reset mid-count, with a read in the reset cycle
        wr(3'd6, 32'd0);
        wr(3'd4, 32'd7);
        idle(5);
        cyc(1, 1, 0, 32'd0, 32'd0, 4'h0, g);
        chk("read_during_rst", g, 32'd0);
        check_reset_table();

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [2:0]  off;
            logic [31:0] d, a;
            logic [3:0]  mk;
            int          op;
            op  = $urandom_range(0, 99);
            off = 3'($urandom_range(0, 7));
            a   = {$urandom_range(0, 255) == 0 ? 27'($urandom) : 27'd0, off, 2'b00};
            mk  = 4'($urandom);
            case (off)
                3'd2:    d = $urandom_range(0, 80);
                3'd3:    d = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
                3'd1:    d = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
                3'd4:    d = ($urandom & 32'hFFFF_FFF8) | (($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(0, 7)));
                3'd6:    d = $urandom_range(0, 3);
                default: d = $urandom;
            endcase
            if (op == 0)       cyc(1, 0, 0, a, d, mk, g);
            else if (op < 40)  cyc(0, 0, $urandom_range(0, 1) == 1, a, d, mk, g);
            else if (op < 75)  cyc(0, 1, 0, a, d, mk, g);
            else               cyc(0, 1, 1, a, d, mk, g);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
